// File: rtl/logic_pipe_pkg.sv
// Shared definitions for logic_pipe: operation encodings and the bitwise
// operation function used by the datapath.
package logic_pipe_pkg;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_NAND = 2'b11;

  // Callers zero-extend narrower operands and truncate the result back.
  localparam int OP_MAX_WIDTH = 64;

  function automatic logic [OP_MAX_WIDTH-1:0] logic_op(
    input logic [OP_MAX_WIDTH-1:0] a,
    input logic [OP_MAX_WIDTH-1:0] b,
    input logic [1:0]              op
  );
    logic [OP_MAX_WIDTH-1:0] r;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      default: r = ~(a & b);
    endcase
    return r;
  endfunction

endpackage

// File: rtl/logic_pipe_stage.sv
// One valid/data pipeline register. Data only updates when a valid item is
// loaded, so a stalled output stays stable.
module logic_pipe_stage #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         v_in,
  input  logic [W-1:0] d_in,
  output logic         v_out,
  output logic [W-1:0] d_out
);

  logic         v_q, v_d;
  logic [W-1:0] d_q, d_d;

  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (load) begin
      v_d = v_in;
      if (v_in) d_d = d_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= 1'b0;
      d_q <= '0;
    end else begin
      v_q <= v_d;
      d_q <= d_d;
    end
  end

  assign v_out = v_q;
  assign d_out = d_q;

endmodule

// File: rtl/logic_pipe.sv
// Selectable bitwise operation on two operands followed by a STAGES-deep
// valid/ready pipeline whose empty stages fill even while the output stalls.
module logic_pipe
  import logic_pipe_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] q,
  output logic             q_zero,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [WIDTH-1:0]  r_d;
  logic              zero_d;
  logic [STAGES-1:0] load;
  logic              v_q [STAGES];
  logic [WIDTH:0]    d_q [STAGES];

  always_comb begin
    r_d    = WIDTH'(logic_op(OP_MAX_WIDTH'(a), OP_MAX_WIDTH'(b), op));
    zero_d = ~|r_d;
  end

  // Walk from the output back: a stage may load if it is empty or its
  // occupant advances, and it advances if the stage after it may load.
  always_comb begin : ready_chain
    logic free;
    free = out_ready;
    load = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      load[i] = ~v_q[i] | (v_q[i] & free);
      free    = load[i];
    end
  end

  assign in_ready = load[0];

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    logic           v_in;
    logic [WIDTH:0] d_in;

    if (gi == 0) begin : g_first
      assign v_in = in_valid;
      assign d_in = {zero_d, r_d};
    end else begin : g_next
      assign v_in = v_q[gi-1];
      assign d_in = d_q[gi-1];
    end

    logic_pipe_stage #(.W(WIDTH + 1)) u_stage (
      .clk   (clk),
      .rst   (rst),
      .load  (load[gi]),
      .v_in  (v_in),
      .d_in  (d_in),
      .v_out (v_q[gi]),
      .d_out (d_q[gi])
    );
  end

  assign q         = d_q[STAGES-1][WIDTH-1:0];
  assign q_zero    = d_q[STAGES-1][WIDTH];
  assign out_valid = v_q[STAGES-1];

endmodule
